// File: rtl/up_dn_counter.sv
// Loadable saturating up/down counter with max/min flags.
// Define UP_DN_COUNTER_WRAP_EN for modulo counting instead of saturation.
module up_dn_counter #(
  parameter int WIDTH = 5
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] IN,
  input  logic             load,
  input  logic             Up,
  input  logic             Down,
  output logic [WIDTH-1:0] Counter,
  output logic             High,
  output logic             Low
);

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] nxt;
  logic             do_load;
  logic             do_down;
  logic             do_up;

  assign High = (Counter == MAX);
  assign Low  = (Counter == ZERO);

  // Priority is folded into one-hot selects: load, then Down, then Up.
  assign do_load = load;
  assign do_down = !load && Down;
  assign do_up   = !load && !Down && Up;

`ifdef UP_DN_COUNTER_WRAP_EN
  assign dec = Counter - ONE;
  assign inc = Counter + ONE;
`else
  assign dec = Low  ? ZERO : Counter - ONE;
  assign inc = High ? MAX  : Counter + ONE;
`endif

  always_comb begin
    nxt = Counter;
    unique case (1'b1)
      do_load: nxt = IN;
      do_down: nxt = dec;
      do_up:   nxt = inc;
      default: nxt = Counter;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) Counter <= ZERO;
    else        Counter <= nxt;
  end

endmodule

// File: tb/tb_up_dn_counter.sv
// Directed and randomized checks of up_dn_counter against an
// arithmetic reference model.
module tb_up_dn_counter;

  localparam int W    = 5;
  localparam int MAXV = (1 << W) - 1;

  logic         CLK;
  logic         rst_n;
  logic [W-1:0] IN;
  logic         load;
  logic         Up;
  logic         Down;
  logic [W-1:0] Counter;
  logic         High;
  logic         Low;

  int vectors;
  int miscompares;
  int m;

  up_dn_counter #(.WIDTH(W)) dut (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .IN      (IN),
    .load    (load),
    .Up      (Up),
    .Down    (Down),
    .Counter (Counter),
    .High    (High),
    .Low     (Low)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int model_next(int c, bit l, bit u, bit d, int v);
    if (l) return v;
`ifdef UP_DN_COUNTER_WRAP_EN
    if (d) return (c + MAXV) % (MAXV + 1);
    if (u) return (c + 1) % (MAXV + 1);
`else
    if (d) return (c > 0) ? c - 1 : 0;
    if (u) return (c < MAXV) ? c + 1 : MAXV;
`endif
    return c;
  endfunction

  task automatic check_all(input string tag);
    logic [W-1:0] exp_c;
    logic         exp_h;
    logic         exp_l;
    exp_c = W'(m);
    exp_h = (m == MAXV);
    exp_l = (m == 0);
    vectors += 3;
    assert (Counter === exp_c) else begin
      miscompares++;
      $error("FAIL %s Counter: observed %0d expected %0d", tag, Counter, exp_c);
    end
    assert (High === exp_h) else begin
      miscompares++;
      $error("FAIL %s High: observed %0b expected %0b", tag, High, exp_h);
    end
    assert (Low === exp_l) else begin
      miscompares++;
      $error("FAIL %s Low: observed %0b expected %0b", tag, Low, exp_l);
    end
  endtask

  task automatic step(input bit l, input bit u, input bit d,
                      input int v, input string tag);
    @(negedge CLK);
    load = l;
    Up   = u;
    Down = d;
    IN   = W'(v);
    @(posedge CLK);
    m = model_next(m, l, u, d, v);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge CLK);
    load = 1'b1;
    Up   = 1'b1;
    Down = 1'b0;
    IN   = W'($urandom_range(1, MAXV));
    #2 rst_n = 1'b0;
    m = 0;
    #1 check_all({tag, "_async"});
    @(posedge CLK);
    #1 check_all({tag, "_held"});
    @(negedge CLK);
    rst_n = 1'b1;
    load  = 1'b0;
    Up    = 1'b0;
    Down  = 1'b0;
    step(0, 0, 0, 0, {tag, "_idle"});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m           = 0;
    load  = 1'b0;
    Up    = 1'b0;
    Down  = 1'b0;
    IN    = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_all("reset_init");
    @(negedge CLK);
    rst_n = 1'b1;
    step(0, 0, 0, 0, "post_reset_idle");

    step(1, 0, 0, 9, "load9");
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, "down_to_floor");
    step(0, 0, 1, 0, "floor_sat");
    step(0, 1, 1, 0, "floor_down_wins");
    step(0, 0, 0, 0, "floor_hold");

    if (m != 0) step(1, 0, 0, 0, "reload0");
    for (int i = 0; i < MAXV; i++) step(0, 1, 0, 0, "up_to_ceiling");
    step(0, 1, 0, 0, "ceiling_sat");
    if (m != MAXV) step(1, 0, 0, MAXV, "reload_max");

    step(0, 0, 1, 0, "down_from_max");
    step(0, 1, 1, 0, "down_priority");
    step(1, 1, 1, 5, "load_priority");

    step(1, 0, 0, 9, "load9_again");
    async_reset("mid_op");

    step(1, 0, 0, 0, "load0");
    step(0, 0, 1, 0, "down_at_zero");
    step(1, 0, 0, MAXV, "load_max");
    step(0, 1, 0, 0, "up_at_max");

    for (int i = 0; i < 600; i++) begin
      int r;
      bit l;
      bit u;
      bit d;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        async_reset("rand");
      end else begin
        l = ($urandom_range(0, 11) == 0);
        u = ($urandom_range(0, 2) != 0);
        d = ($urandom_range(0, 2) == 0);
        step(l, u, d, int'($urandom_range(0, MAXV)), "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
